// File: rtl/altera_tse_rgmii_rx_sfd_align_if.sv
// altera_tse_rgmii_rx_sfd_align_if: GMII/MII receive inputs and framed byte stream outputs
interface altera_tse_rgmii_rx_sfd_align_if;
    logic speed;
    logic [7:0] gm_rx_d;
    logic gm_rx_dv;
    logic gm_rx_err;
    logic [3:0] m_rx_d;
    logic m_rx_en;
    logic m_rx_err;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_sop;
    logic rx_eop;
    logic rx_err;
    logic [15:0] rx_len;
    logic rx_drop;
    modport master (
        output speed, gm_rx_d, gm_rx_dv, gm_rx_err, m_rx_d, m_rx_en, m_rx_err,
        input rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_len, rx_drop
    );
    modport slave (
        input speed, gm_rx_d, gm_rx_dv, gm_rx_err, m_rx_d, m_rx_en, m_rx_err,
        output rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_len, rx_drop
    );
endinterface

// File: rtl/altera_tse_rgmii_rx_sfd_align.sv
// altera_tse_rgmii_rx_sfd_align: strips preamble/SFD from GMII or MII receive data and emits framed bytes
module altera_tse_rgmii_rx_sfd_align #(
    parameter int MIN_PRE = 1,
    parameter int MAX_LEN = 1518
) (
    input logic rx_clk,
    input logic reset_rx_clk_n,
    altera_tse_rgmii_rx_sfd_align_if.slave bus
);
    localparam logic [15:0] MIN_P = 16'(MIN_PRE);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
    state_t state, state_n;
    logic spd, spd_n, hold_v, hold_v_n, nib, nib_n, bad, bad_n, first, first_n;
    logic [3:0] lo, lo_n;
    logic [7:0] hold, hold_n;
    logic [15:0] pre_cnt, pre_cnt_n, len, len_n;
    logic [7:0] rx_data, rx_data_n;
    logic rx_valid, rx_valid_n, rx_sop, rx_sop_n, rx_eop, rx_eop_n, rx_err, rx_err_n, rx_drop, rx_drop_n;
    logic [15:0] rx_len, rx_len_n;
    logic eff, dv, err, is_pre, is_sfd;
    logic [7:0] d, byte_in;
    logic [15:0] pre_cur;
    // In IDLE the live speed selects the lane; afterwards the value latched on frame start does
    assign eff = (state == IDLE) ? bus.speed : spd;
    assign dv = eff ? bus.gm_rx_dv : bus.m_rx_en;
    assign err = eff ? bus.gm_rx_err : bus.m_rx_err;
    assign d = eff ? bus.gm_rx_d : {4'h0, bus.m_rx_d};
    assign is_pre = eff ? d == 8'h55 : d[3:0] == 4'h5;
    assign is_sfd = eff ? d == 8'hD5 : d[3:0] == 4'hD;
    assign pre_cur = (state == IDLE) ? 16'd0 : pre_cnt;
    assign byte_in = eff ? d : {d[3:0], lo};
    always_comb begin
        state_n = state;
        spd_n = (state == IDLE && dv) ? bus.speed : spd;
        pre_cnt_n = pre_cnt;
        hold_n = hold;
        hold_v_n = hold_v;
        lo_n = lo;
        nib_n = nib;
        len_n = len;
        bad_n = bad;
        first_n = first;
        rx_data_n = 8'h00;
        rx_valid_n = 1'b0;
        rx_sop_n = 1'b0;
        rx_eop_n = 1'b0;
        rx_err_n = 1'b0;
        rx_len_n = 16'h0000;
        rx_drop_n = 1'b0;
        case (state)
            IDLE, PRE: begin
                if (!dv) begin
                    state_n = IDLE;
                end else if (err) begin
                    state_n = DROP;
                end else if (is_pre) begin
                    state_n = PRE;
                    pre_cnt_n = (pre_cur >= MIN_P) ? pre_cur : pre_cur + 16'd1;
                end else if (is_sfd && pre_cur >= MIN_P) begin
                    state_n = DATA;
                    hold_v_n = 1'b0;
                    nib_n = 1'b0;
                    len_n = 16'd0;
                    bad_n = 1'b0;
                    first_n = 1'b1;
                end else begin
                    state_n = DROP;
                end
            end
            DATA: begin
                if (!dv) begin
                    state_n = IDLE;
                    rx_valid_n = hold_v;
                    rx_data_n = hold_v ? hold : 8'h00;
                    rx_sop_n = hold_v & first;
                    rx_eop_n = hold_v;
                    rx_err_n = hold_v & (bad | nib | (len > MAX_L));
                    rx_len_n = hold_v ? len : 16'h0000;
                    rx_drop_n = !hold_v;
                end else begin
                    bad_n = bad | err;
                    if (eff | nib) begin
                        hold_n = byte_in;
                        hold_v_n = 1'b1;
                        nib_n = 1'b0;
                        len_n = (&len) ? len : len + 16'd1;
                        rx_valid_n = hold_v;
                        rx_data_n = hold_v ? hold : 8'h00;
                        rx_sop_n = hold_v & first;
                        first_n = first & !hold_v;
                    end else begin
                        lo_n = d[3:0];
                        nib_n = 1'b1;
                    end
                end
            end
            DROP: begin
                state_n = dv ? DROP : IDLE;
                rx_drop_n = !dv;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge rx_clk or negedge reset_rx_clk_n) begin
        if (!reset_rx_clk_n) begin
            state <= IDLE;
            spd <= 1'b0;
            pre_cnt <= 16'd0;
            hold <= 8'h00;
            hold_v <= 1'b0;
            lo <= 4'h0;
            nib <= 1'b0;
            len <= 16'd0;
            bad <= 1'b0;
            first <= 1'b0;
            rx_data <= 8'h00;
            rx_valid <= 1'b0;
            rx_sop <= 1'b0;
            rx_eop <= 1'b0;
            rx_err <= 1'b0;
            rx_len <= 16'h0000;
            rx_drop <= 1'b0;
        end else begin
            state <= state_n;
            spd <= spd_n;
            pre_cnt <= pre_cnt_n;
            hold <= hold_n;
            hold_v <= hold_v_n;
            lo <= lo_n;
            nib <= nib_n;
            len <= len_n;
            bad <= bad_n;
            first <= first_n;
            rx_data <= rx_data_n;
            rx_valid <= rx_valid_n;
            rx_sop <= rx_sop_n;
            rx_eop <= rx_eop_n;
            rx_err <= rx_err_n;
            rx_len <= rx_len_n;
            rx_drop <= rx_drop_n;
        end
    end
    assign bus.rx_data = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_sop = rx_sop;
    assign bus.rx_eop = rx_eop;
    assign bus.rx_err = rx_err;
    assign bus.rx_len = rx_len;
    assign bus.rx_drop = rx_drop;
endmodule
